// File: rtl/id_tx.sv
// id_tx: serialises one captured ID word as start(0), data LSB first, even parity, stop(1).
// Latency: TXD/BUSY change on the edge that accepts START; frame is (ID_WIDTH+3)*CLKS_PER_BIT cycles.
// Backpressure: START is level-sampled only when idle or on the final stop-bit edge; otherwise ignored.
//
// Ports:
//   CLK    in   single clock, rising-edge
//   RESET  in   synchronous, active-high; overrides START
//   ID     in   ID_WIDTH identifier word, sampled only when a frame is accepted
//   START  in   request one frame
//   TXD    out  serial line, idle high
//   BUSY   out  high while a frame is in progress
//   DONE   out  one-cycle pulse after the stop bit completes
module id_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int ID_WIDTH     = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ID_WIDTH-1:0] ID,
  input  logic                START,
  output logic                TXD,
  output logic                BUSY,
  output logic                DONE
);

  localparam int IW = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state;
  logic [7:0]          baud;
  logic [IW-1:0]       bit_idx;
  logic [ID_WIDTH-1:0] shreg;
  logic                parity;

  logic                bit_end;
  logic [ID_WIDTH-1:0] shreg_nxt;

  assign bit_end   = (baud == 8'(CLKS_PER_BIT - 1));
  assign shreg_nxt = shreg >> 1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      TXD     <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            shreg   <= ID;
            parity  <= ^ID;
            baud    <= '0;
            bit_idx <= '0;
            state   <= START_BIT;
            TXD     <= 1'b0;
            BUSY    <= 1'b1;
          end else begin
            TXD  <= 1'b1;
            BUSY <= 1'b0;
          end
        end

        START_BIT: begin
          if (bit_end) begin
            baud  <= '0;
            state <= DATA;
            TXD   <= shreg[0];
          end else begin
            baud <= baud + 8'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == IW'(ID_WIDTH - 1)) begin
              state <= PARITY;
              TXD   <= parity;
            end else begin
              // TXD always mirrors shreg[0]; shift and present the next bit together.
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg_nxt;
              TXD     <= shreg_nxt[0];
            end
          end else begin
            baud <= baud + 8'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            state <= STOP;
            TXD   <= 1'b1;
          end else begin
            baud <= baud + 8'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud <= '0;
            DONE <= 1'b1;
            // A START present as the stop bit ends chains the next frame directly,
            // so its start bit occupies the DONE cycle and no idle-high gap appears.
            if (START) begin
              shreg   <= ID;
              parity  <= ^ID;
              bit_idx <= '0;
              state   <= START_BIT;
              TXD     <= 1'b0;
            end else begin
              state <= IDLE;
              TXD   <= 1'b1;
              BUSY  <= 1'b0;
            end
          end else begin
            baud <= baud + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          TXD   <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
